// File: rtl/idea_c_seq_checker.sv
// idea_c_seq_checker: run-time monitor that locks onto the IdeaC down-counter stream and flags deviations
// Ports: clk, rst_n (async active-low), ce (sample strobe), in (observed state),
//        next_exp (expected next sample), locked, err (1-cycle mismatch pulse),
//        err_cnt (saturating mismatch count), pos (HI-in of last accepted sample)
module idea_c_seq_checker #(
  parameter int WIDTH    = 4,
  parameter int HI       = 14,
  parameter int LO       = 5,
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] next_exp,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [3:0]       pos
);
  localparam int CW = $clog2(LOCK_CNT + 1);
  localparam logic [WIDTH-1:0] HI_V = WIDTH'(HI);
  localparam logic [WIDTH-1:0] LO_V = WIDTH'(LO);
  localparam logic [CW-1:0] LC_V = CW'(LOCK_CNT);
  localparam logic L1 = (LOCK_CNT == 1);
  typedef enum logic [1:0] {HUNT, SYNC, LOCK} state_t;
  state_t state;
  logic [CW-1:0] cnt, cnt_inc;
  logic [WIDTH-1:0] nx;
  logic [3:0] pv;
  logic rng, hit, miss;
  always_comb begin
    rng = (in >= LO_V) && (in <= HI_V);
    nx = (in == LO_V) ? HI_V : in - 1'b1;
    pv = 4'(HI_V - in);
    // HUNT has no valid expectation, so nothing can match there
    hit = (state != HUNT) && (in == next_exp);
    miss = (state == LOCK) && !hit;
    cnt_inc = (cnt == LC_V) ? cnt : cnt + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HUNT;
      next_exp <= '0;
      locked <= 1'b0;
      err <= 1'b0;
      err_cnt <= '0;
      pos <= '0;
      cnt <= '0;
    end else begin
      err <= ce && miss;
      if (ce) begin
        if (miss && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        if (hit) begin
          next_exp <= nx;
          pos <= pv;
          cnt <= cnt_inc;
          if (cnt_inc == LC_V) begin
            state <= LOCK;
            locked <= 1'b1;
          end
        end else if (rng) begin
          // any in-range sample that breaks the chain reseeds from itself
          next_exp <= nx;
          pos <= pv;
          cnt <= CW'(1);
          state <= L1 ? LOCK : SYNC;
          locked <= L1;
        end else begin
          state <= HUNT;
          locked <= 1'b0;
          cnt <= '0;
        end
      end
    end
  end
endmodule
